// File: rtl/instr_reader.sv
// instr_reader: streams a burst of instruction-register entries to a valid/ready consumer.
// Optional result checker is built only when INSTR_READER_CHECK_EN is defined.
package instr_reader_pkg;
    typedef logic [4:0] address_t;

    typedef struct packed {
        logic [3:0]         opc;
        logic signed [31:0] op_a;
        logic signed [31:0] op_b;
        logic signed [31:0] op_c;
        logic signed [63:0] result;
    } instruction_t;

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;
endpackage

module instr_reader
    import instr_reader_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [4:0]   first_addr,
    input  logic [5:0]   count,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         out_valid,
    input  logic         out_ready,
    output instruction_t out_instr,
    output address_t     out_index,
    output logic         busy,
    output logic         done,
    output logic         out_mismatch,
    output logic [7:0]   err_count
);
    // Handshake: an instruction moves on every rising edge where out_valid and
    // out_ready are both 1; out_instr/out_index hold steady while out_valid waits.
    typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

    state_t     state, state_next;
    logic [5:0] remaining;
    logic       load, capture, xfer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        xfer       = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && (count != 6'd0)) begin
                    load       = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                capture    = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    xfer       = 1'b1;
                    // remaining==1 means this transfer drains the burst.
                    state_next = (remaining == 6'd1) ? FIN : FETCH;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer <= '0;
            remaining    <= '0;
            out_instr    <= '0;
            out_index    <= '0;
        end else begin
            if (load) begin
                read_pointer <= first_addr;
                remaining    <= count;
            end else if (xfer) begin
                remaining <= remaining - 6'd1;
                if (remaining != 6'd1) begin
                    read_pointer <= read_pointer + 5'd1;
                end
            end
            if (capture) begin
                out_instr <= instruction_word;
                out_index <= read_pointer;
            end
        end
    end

`ifdef INSTR_READER_CHECK_EN
    logic signed [63:0] chk_a, chk_b, chk_c, chk_expected;
    logic               chk_skip, chk_mismatch, mismatch_q;
    logic [7:0]         err_q;

    always_comb begin
        chk_a        = {{32{instruction_word.op_a[31]}}, instruction_word.op_a};
        chk_b        = {{32{instruction_word.op_b[31]}}, instruction_word.op_b};
        chk_c        = {{32{instruction_word.op_c[31]}}, instruction_word.op_c};
        chk_expected = '0;
        chk_skip     = 1'b0;
        case (instruction_word.opc)
            OP_ZERO:  chk_expected = '0;
            OP_PASSA: chk_expected = chk_a;
            OP_PASSB: chk_expected = chk_b;
            OP_ADD:   chk_expected = chk_a + chk_b + chk_c;
            OP_SUB:   chk_expected = chk_a - chk_b;
            OP_MULT:  chk_expected = chk_a * chk_b;
            OP_DIV: begin
                if (chk_b == 64'sd0) chk_skip = 1'b1;
                else                 chk_expected = chk_a / chk_b;
            end
            OP_MOD: begin
                if (chk_b == 64'sd0) chk_skip = 1'b1;
                else                 chk_expected = chk_a % chk_b;
            end
            default: chk_skip = 1'b1;
        endcase
        chk_mismatch = !chk_skip && (chk_expected != instruction_word.result);
    end

    // Verdict is latched alongside out_instr so it is valid for the whole SEND wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            if (capture) begin
                mismatch_q <= chk_mismatch;
            end
            if (xfer && mismatch_q && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign out_mismatch = mismatch_q;
    assign err_count    = err_q;
`else
    assign out_mismatch = 1'b0;
    assign err_count    = '0;
`endif

endmodule

// File: tb/tb_instr_reader.sv
// Self-checking bench for instr_reader: burst-level model with an expected-index queue.
module tb_instr_reader;
    import instr_reader_pkg::*;

`ifdef INSTR_READER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef logic [163:0] v_t;

    logic         clk, reset_n, start, out_valid, out_ready, busy, done, out_mismatch;
    logic [4:0]   first_addr;
    logic [5:0]   count;
    address_t     read_pointer, out_index;
    instruction_t instruction_word, out_instr;
    logic [7:0]   err_count;

    instruction_t mem [32];
    assign instruction_word = mem[read_pointer];

    instr_reader dut (
        .clk(clk), .reset_n(reset_n), .start(start), .first_addr(first_addr),
        .count(count), .read_pointer(read_pointer), .instruction_word(instruction_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_index(out_index), .busy(busy), .done(done),
        .out_mismatch(out_mismatch), .err_count(err_count)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected the run to finish");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int         cnt_cmp = 0;
    int         cnt_bad = 0;
    logic [4:0] exp_q[$];
    int         got_idx[$], got_mm[$], xfer_cyc[$], exp_seq[$];
    logic       done_exp = 1'b0, after_xfer = 1'b0, model_busy_now = 1'b0;
    logic       xfer_now, mm;
    logic [4:0] cur;
    int         model_err = 0;
    int         start_cyc = 0;
    instruction_t snap;

    task automatic chk(input string name, input v_t got, input v_t exp);
        cnt_cmp++;
        if (got !== exp) begin
            cnt_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected checker verdict straight from the opcode table.
    function automatic logic model_mismatch(input instruction_t w);
        longint a, b, c, e;
        a = longint'($signed(w.op_a));
        b = longint'($signed(w.op_b));
        c = longint'($signed(w.op_c));
        e = 0;
        if (!CHECK_EN) return 1'b0;
        case (w.opc)
            4'd0: e = 0;
            4'd1: e = a;
            4'd2: e = b;
            4'd3: e = a + b + c;
            4'd4: e = a - b;
            4'd5: e = a * b;
            4'd6: begin if (b == 0) return 1'b0; e = a / b; end
            4'd7: begin if (b == 0) return 1'b0; e = a % b; end
            default: return 1'b0;
        endcase
        return e != longint'($signed(w.result));
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            chk("done", v_t'(done), v_t'(done_exp));
            model_busy_now = (exp_q.size() != 0) || done_exp;
            chk("busy", v_t'(busy), v_t'(model_busy_now));
            chk("err_count", v_t'(err_count), v_t'(model_err));
            if (after_xfer || exp_q.size() == 0) chk("valid_low", v_t'(out_valid), '0);
            xfer_now = out_valid && out_ready;
            if (out_valid && exp_q.size() != 0) begin
                cur = exp_q[0];
                mm  = model_mismatch(mem[cur]);
                chk("out_index", v_t'(out_index), v_t'(cur));
                chk("out_instr", v_t'(out_instr), v_t'(mem[cur]));
                chk("read_pointer", v_t'(read_pointer), v_t'(cur));
                chk("out_mismatch", v_t'(out_mismatch), v_t'(mm));
                if (out_ready) begin
                    got_idx.push_back(int'(out_index));
                    got_mm.push_back(int'(out_mismatch));
                    xfer_cyc.push_back(cyc);
                    if (mm && model_err < 255) model_err++;
                    void'(exp_q.pop_front());
                end
            end
            done_exp   = xfer_now && (exp_q.size() == 0);
            after_xfer = xfer_now;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_entry(input int i, input logic [3:0] opc, input int a, input int b,
                             input int c, input longint res);
        mem[i].opc    = opc;
        mem[i].op_a   = a;
        mem[i].op_b   = b;
        mem[i].op_c   = c;
        mem[i].result = res;
    endtask

    task automatic init_mem();
        for (int i = 0; i < 32; i++) set_entry(i, OP_PASSA, i * 3 - 40, i, -i, longint'(i * 3 - 40));
        set_entry(0, OP_SUB, 100, 58, 0, 42);
        set_entry(1, OP_MOD, 17, 5, 0, 2);
        for (int i = 2; i <= 4; i++) set_entry(i, OP_ADD, 5, -3, 1, 3);
        set_entry(5, OP_MULT, 1000, -3, 0, -3000);
        set_entry(6, OP_DIV, -100, 7, 0, -14);
        set_entry(10, OP_SUB, 10, 4, 0, 7);
        set_entry(11, OP_DIV, 9, 0, 0, 123);
        set_entry(12, OP_DIV, -9, 2, 0, -4);
        set_entry(13, OP_MULT, -7, 6, 0, -42);
        set_entry(14, OP_MOD, -7, 3, 0, -1);
        set_entry(15, 4'd9, 1, 2, 3, 999);
        set_entry(30, OP_PASSB, 0, -77, 0, -77);
        set_entry(31, OP_ZERO, 8, 9, 10, 0);
    endtask

    task automatic clear_logs();
        got_idx.delete();
        got_mm.delete();
        xfer_cyc.delete();
    endtask

    task automatic model_reset();
        exp_q.delete();
        done_exp       = 1'b0;
        after_xfer     = 1'b0;
        model_busy_now = 1'b0;
        model_err      = 0;
    endtask

    // Call just after a rising edge; returns just after the edge that samples start.
    task automatic start_burst(input int first, input int n);
        bit accept;
        start      = 1'b1;
        first_addr = 5'(first);
        count      = 6'(n);
        @(negedge clk); #1;
        accept = (n != 0) && !model_busy_now;
        @(posedge clk); #1;
        start = 1'b0;
        if (accept) begin
            start_cyc = cyc;
            for (int k = 0; k < n; k++) exp_q.push_back(5'((first + k) % 32));
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (!busy && exp_q.size() == 0 && !done_exp) ok = 1'b1;
        end
        chk({name, "_idle_timeout"}, v_t'(ok), v_t'(1));
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            if (out_valid) ok = 1'b1;
        end
        chk({name, "_valid_timeout"}, v_t'(ok), v_t'(1));
    endtask

    task automatic check_seq(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, v_t'(got.size()), v_t'(exp.size()));
        for (int k = 0; k < exp.size(); k++) begin
            if (k < got.size()) chk(name, v_t'(got[k]), v_t'(exp[k]));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        first_addr = '0;
        count      = '0;
        out_ready  = 1'b1;
        init_mem();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read_pointer", v_t'(read_pointer), '0);
        chk("rst_out_instr", v_t'(out_instr), '0);
        chk("rst_out_index", v_t'(out_index), '0);
        chk("rst_out_valid", v_t'(out_valid), '0);
        chk("rst_busy", v_t'(busy), '0);
        chk("rst_done", v_t'(done), '0);
        chk("rst_mismatch", v_t'(out_mismatch), '0);
        chk("rst_err_count", v_t'(err_count), '0);

        // Basic burst, started on the first edge after reset release.
        reset_n = 1'b1;
        clear_logs();
        start_burst(2, 3);
        wait_idle("basic", 40);
        exp_seq = {2, 3, 4};
        check_seq("basic_idx", got_idx, exp_seq);
        exp_seq = {start_cyc + 1, start_cyc + 3, start_cyc + 5};
        check_seq("basic_cycles", xfer_cyc, exp_seq);
        chk("basic_rp_hold", v_t'(read_pointer), v_t'(4));

        // count=0 is ignored.
        start_burst(9, 0);
        @(posedge clk); #1;
        chk("count0_busy", v_t'(busy), '0);
        chk("count0_rp", v_t'(read_pointer), v_t'(4));

        // Address wrap 31 -> 0.
        clear_logs();
        start_burst(30, 4);
        wait_idle("wrap", 40);
        exp_seq = {30, 31, 0, 1};
        check_seq("wrap_idx", got_idx, exp_seq);

        // Consumer stall plus a start while busy.
        clear_logs();
        out_ready = 1'b0;
        start_burst(5, 2);
        wait_valid("stall", 10);
        snap = out_instr;
        chk("stall_first", v_t'(snap), v_t'(mem[5]));
        start_burst(20, 2);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", v_t'(out_valid), v_t'(1));
            chk("stall_instr", v_t'(out_instr), v_t'(snap));
        end
        out_ready = 1'b1;
        wait_idle("stall", 40);
        exp_seq = {5, 6};
        check_seq("stall_idx", got_idx, exp_seq);

        // Reset during SEND of the third of five entries.
        clear_logs();
        out_ready = 1'b0;
        start_burst(12, 5);
        for (int k = 0; k < 2; k++) begin
            wait_valid("rst_burst", 10);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        wait_valid("rst_third", 10);
        chk("rst_third_index", v_t'(out_index), v_t'(14));
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("abort_valid", v_t'(out_valid), '0);
        chk("abort_busy", v_t'(busy), '0);
        chk("abort_rp", v_t'(read_pointer), '0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_done", v_t'(done), '0);
        end
        reset_n   = 1'b1;
        out_ready = 1'b1;
        clear_logs();
        start_burst(20, 2);
        wait_idle("after_rst", 40);
        exp_seq = {20, 21};
        check_seq("after_rst_idx", got_idx, exp_seq);

        // Checker: SUB mismatch, DIV-by-zero and opcode 9 skipped.
        clear_logs();
        start_burst(10, 6);
        wait_idle("check", 60);
        if (CHECK_EN) exp_seq = {1, 0, 0, 0, 0, 0};
        else          exp_seq = {0, 0, 0, 0, 0, 0};
        check_seq("check_mm", got_mm, exp_seq);
        chk("check_err", v_t'(err_count), CHECK_EN ? v_t'(1) : v_t'(0));

        // Long bursts of mismatching entries: count>32 re-reads and err_count saturates.
        for (int i = 0; i < 32; i++) set_entry(i, OP_ZERO, i, 0, 0, 1);
        clear_logs();
        start_burst(3, 63);
        wait_idle("long", 300);
        chk("long_len", v_t'(got_idx.size()), v_t'(63));
        if (got_idx.size() == 63) begin
            chk("long_idx29", v_t'(got_idx[29]), v_t'(0));
            chk("long_idx32", v_t'(got_idx[32]), v_t'(3));
            chk("long_idx62", v_t'(got_idx[62]), v_t'(1));
        end
        chk("long_err", v_t'(err_count), CHECK_EN ? v_t'(64) : v_t'(0));
        for (int r = 0; r < 4; r++) begin
            start_burst(0, 63);
            wait_idle("sat", 300);
        end
        chk("sat_err", v_t'(err_count), CHECK_EN ? v_t'(255) : v_t'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
        $finish;
    end

endmodule
